// File: rtl/cpu_run_controller.sv
// CPU run controller: decodes mouse-zone commands into a run state, a
// programmable-rate CPU tick, a speed level and a memory-reset pulse.
module cpu_run_controller #(
  parameter int         CLOCK_FREQUENCY = 50000000,
  parameter int         BASE_RATE       = 1,
  parameter logic [5:0] Z_SPEEDUP       = 6'd1,
  parameter logic [5:0] Z_START         = 6'd5,
  parameter logic [5:0] Z_STEP          = 6'd6,
  parameter logic [5:0] Z_RESET         = 6'd7,
  parameter logic [5:0] Z_STOP          = 6'd8
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        O_selection,
  input  logic [5:0]  SELECTED_ZONE,
  input  logic        cpu_error,
  output logic        cpu_tick,
  output logic        cpu_run,
  output logic        ui_mode,
  output logic        mem_reset,
  output logic [1:0]  speed_level,
  output logic [1:0]  run_state,
  output logic [15:0] tick_count
);

  localparam int BASE_PERIOD = CLOCK_FREQUENCY / BASE_RATE;
  localparam int CNT_W       = $clog2(BASE_PERIOD);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    FAULT  = 2'd3
  } state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [1:0]         speed_nx;
  logic               tick_nx, mem_reset_nx;
  logic [15:0]        tick_count_nx;
  logic               sel_prev;
  logic               click;
  logic               cmd_speedup, cmd_start, cmd_step, cmd_reset, cmd_stop;

  // Last divider count for a speed level: (BASE_PERIOD >> speed) - 1.
  function automatic logic [CNT_W-1:0] period_last(input logic [1:0] spd);
    return CNT_W'((BASE_PERIOD >> spd) - 1);
  endfunction

  assign run_state = state;
  assign cpu_run   = (state == RUN);
  assign ui_mode   = (state == IDLE);

  // Command decode: one command per rising edge of the click level.
  always_comb begin
    click       = O_selection & ~sel_prev;
    cmd_speedup = click && (SELECTED_ZONE == Z_SPEEDUP);
    cmd_start   = click && (SELECTED_ZONE == Z_START);
    cmd_step    = click && (SELECTED_ZONE == Z_STEP);
    cmd_reset   = click && (SELECTED_ZONE == Z_RESET);
    cmd_stop    = click && (SELECTED_ZONE == Z_STOP);
  end

  // Next-state, divider and pulse logic; error beats RESET beats the rest.
  // A tick falling due on a cycle that leaves RUN is dropped, so ticks only
  // ever issue while the controller stays in RUN (or from a STEP).
  always_comb begin
    state_nx      = state;
    speed_nx      = speed_level;
    cnt_nx        = cnt;
    tick_nx       = 1'b0;
    mem_reset_nx  = 1'b0;
    tick_count_nx = tick_count;
    unique case (state)
      IDLE: begin
        if (cmd_start) begin
          state_nx      = RUN;
          speed_nx      = 2'd0;
          cnt_nx        = '0;
          tick_count_nx = 16'd0;
        end
      end
      RUN: begin
        if (cpu_error) begin
          state_nx = FAULT;
          cnt_nx   = '0;
        end else if (cmd_reset) begin
          state_nx      = IDLE;
          mem_reset_nx  = 1'b1;
          speed_nx      = 2'd0;
          cnt_nx        = '0;
          tick_count_nx = 16'd0;
        end else if (cmd_stop) begin
          state_nx = PAUSED;
          speed_nx = 2'd0;
          cnt_nx   = '0;
        end else begin
          if (cnt == period_last(speed_level)) begin
            tick_nx = 1'b1;
            cnt_nx  = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
          if (cmd_speedup) begin
            speed_nx = speed_level + 2'd1;
            cnt_nx   = '0;
          end
        end
      end
      PAUSED: begin
        if (cpu_error) begin
          state_nx = FAULT;
        end else if (cmd_reset) begin
          state_nx      = IDLE;
          mem_reset_nx  = 1'b1;
          speed_nx      = 2'd0;
          tick_count_nx = 16'd0;
        end else if (cmd_step) begin
          tick_nx = 1'b1;
        end else if (cmd_start) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end
      end
      FAULT: begin
        if (cmd_reset) begin
          state_nx      = IDLE;
          mem_reset_nx  = 1'b1;
          speed_nx      = 2'd0;
          cnt_nx        = '0;
          tick_count_nx = 16'd0;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (tick_nx) tick_count_nx = tick_count + 16'd1;
  end

  // State, divider, pulses and click-edge register; reset kills any pulse.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      speed_level <= 2'd0;
      cnt         <= '0;
      cpu_tick    <= 1'b0;
      mem_reset   <= 1'b0;
      tick_count  <= 16'd0;
      sel_prev    <= 1'b0;
    end else begin
      state       <= state_nx;
      speed_level <= speed_nx;
      cnt         <= cnt_nx;
      cpu_tick    <= tick_nx;
      mem_reset   <= mem_reset_nx;
      tick_count  <= tick_count_nx;
      sel_prev    <= O_selection;
    end
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Scoreboard bench for cpu_run_controller: a time-based reference model
// predicts every cycle's outputs, a monitor compares them against the DUT.
module tb_cpu_run_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        O_selection = 1'b0;
  logic [5:0]  SELECTED_ZONE = 6'd0;
  logic        cpu_error = 1'b0;
  logic        cpu_tick, cpu_run, ui_mode, mem_reset;
  logic [1:0]  speed_level, run_state;
  logic [15:0] tick_count;

  cpu_run_controller #(.CLOCK_FREQUENCY(16), .BASE_RATE(1)) dut (
    .CLOCK_50(clk), .reset_n(reset_n), .O_selection(O_selection),
    .SELECTED_ZONE(SELECTED_ZONE), .cpu_error(cpu_error),
    .cpu_tick(cpu_tick), .cpu_run(cpu_run), .ui_mode(ui_mode),
    .mem_reset(mem_reset), .speed_level(speed_level),
    .run_state(run_state), .tick_count(tick_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  logic [23:0] exp_q[$];
  logic [23:0] dut_out;
  assign dut_out = {run_state, speed_level, cpu_tick, mem_reset, cpu_run, ui_mode, tick_count};

  localparam logic [23:0] RST_VAL = {2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0};

  // Reference model: state named by number, ticks scheduled by absolute cycle.
  int m_state, m_speed, m_count, m_next, cyc;
  bit m_prev;

  function automatic int period(input int spd);
    return 16 >> spd;
  endfunction

  function automatic logic [23:0] pack(input int st, input int spd, input bit tk,
                                       input bit mr, input int cnt);
    logic [1:0]  s2, p2;
    logic [15:0] c16;
    s2 = st[1:0]; p2 = spd[1:0]; c16 = cnt[15:0];
    return {s2, p2, tk, mr, (st == 1), (st == 0), c16};
  endfunction

  task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got st=%0d spd=%0d tick=%0b mr=%0b run=%0b ui=%0b cnt=%0d, expected st=%0d spd=%0d tick=%0b mr=%0b run=%0b ui=%0b cnt=%0d",
               name, $time, got[23:22], got[21:20], got[19], got[18], got[17], got[16], got[15:0],
               exp[23:22], exp[21:20], exp[19], exp[18], exp[17], exp[16], exp[15:0]);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_speed = 0; m_count = 0; m_prev = 0;
    cyc++;
  endtask

  task automatic model_step(input bit sel, input int zone, input bit err);
    bit tk, mr, clk_ev;
    tk = 0; mr = 0;
    cyc++;
    clk_ev = sel && !m_prev;
    m_prev = sel;
    case (m_state)
      0: if (clk_ev && zone == 5) begin
           m_state = 1; m_speed = 0; m_count = 0; m_next = cyc + period(0);
         end
      1: if (err) m_state = 3;
         else if (clk_ev && zone == 7) begin
           m_state = 0; mr = 1; m_count = 0; m_speed = 0;
         end else if (clk_ev && zone == 8) begin
           m_state = 2; m_speed = 0;
         end else begin
           if (cyc == m_next) begin
             tk = 1; m_next = cyc + period(m_speed);
           end
           if (clk_ev && zone == 1) begin
             m_speed = (m_speed + 1) % 4; m_next = cyc + period(m_speed);
           end
         end
      2: if (err) m_state = 3;
         else if (clk_ev && zone == 7) begin
           m_state = 0; mr = 1; m_count = 0; m_speed = 0;
         end else if (clk_ev && zone == 6) tk = 1;
         else if (clk_ev && zone == 5) begin
           m_state = 1; m_next = cyc + period(m_speed);
         end
      default: if (clk_ev && zone == 7) begin
           m_state = 0; mr = 1; m_count = 0; m_speed = 0;
         end
    endcase
    if (tk) m_count = (m_count + 1) % 65536;
    exp_q.push_back(pack(m_state, m_speed, tk, mr, m_count));
  endtask

  task automatic cycle(input bit sel, input int zone, input bit err);
    @(negedge clk);
    reset_n = 1'b1;
    O_selection = sel;
    SELECTED_ZONE = zone[5:0];
    cpu_error = err;
    model_step(sel, zone, err);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0);
  endtask

  task automatic click(input int zone);
    cycle(1, zone, 0);
    cycle(0, zone, 0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    O_selection = 1'b0;
    cpu_error = 1'b0;
    #2 reset_n = 1'b0;
    #1 check("async_reset_immediate", dut_out, RST_VAL);
    model_reset();
    exp_q.push_back(RST_VAL);
  endtask

  // Monitor: pop and compare one expected snapshot after each clock edge.
  initial begin
    logic [23:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle_outputs", dut_out, e);
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized clicks and errors.
  initial begin
    int zones[6];
    int z, n, guard;
    bit err;
    zones = '{1, 5, 6, 7, 8, 3};
    m_state = 0; m_speed = 0; m_count = 0; m_next = 0; m_prev = 0; cyc = 0;
    #1 check("reset_state", dut_out, RST_VAL);

    idle(3);
    // start and base-rate ticks
    click(5);
    idle(16 * 5 + 2);
    // speedup through all levels and wrap
    for (int k = 0; k < 4; k++) begin
      click(1);
      idle(25);
    end
    idle(20);
    // pause, quiet period, step, held step
    click(8);
    idle(100);
    click(6);
    idle(3);
    for (int i = 0; i < 50; i++) cycle(1, 6, 0);
    idle(3);
    // fault on a tick-due cycle
    click(5);
    guard = 0;
    while (cyc + 1 != m_next && guard < 40) begin
      cycle(0, 0, 0);
      guard++;
    end
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    click(5);
    click(6);
    idle(5);
    click(7);
    idle(3);
    // error and reset click together
    click(5);
    idle(5);
    cycle(1, 7, 1);
    cycle(0, 0, 0);
    idle(3);
    click(7);
    idle(3);
    // async reset mid-run, then no ticks until restarted
    click(5);
    idle(20);
    async_reset();
    idle(40);
    click(5);
    idle(20);

    // random phase
    for (int it = 0; it < 1500; it++) begin
      err = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 12) begin
        z = zones[$urandom_range(0, 5)];
        n = $urandom_range(1, 3);
        for (int j = 0; j < n; j++) cycle(1, z, err);
      end else begin
        cycle(0, 0, err);
      end
    end
    idle(5);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (exp_q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain: %0d expected snapshots left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
